// File: rtl/aes_spi_master.sv
// aes_spi_master: shifts a 128-bit block then an Nk-word key LSB-first onto SIMO, waits TURN
// cycles, then captures a 128-bit result from SOMI. Define AES_SPI_MASTER_SS_EN to add ss_n.
module aes_spi_master #(
    parameter int Nk   = 4,
    parameter int TURN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode_in,
    input  logic [127:0]     msg_in,
    input  logic [Nk*32-1:0] key_in,
    output logic             SIMO,
    output logic             mode,
    input  logic             SOMI,
    output logic [127:0]     result,
    output logic             busy,
    output logic             done
`ifdef AES_SPI_MASTER_SS_EN
    ,
    output logic             ss_n
`endif
);
    localparam int         KB       = Nk * 32;
    localparam logic [7:0] KEY_LAST = 8'(KB - 1);
    localparam logic [7:0] GAP_LAST = 8'((TURN > 0) ? TURN - 1 : 0);

    typedef enum logic [2:0] {IDLE, MSG, KEY, GAP, RX, DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [127:0]  msg_q, msg_d;
    logic [KB-1:0] key_q, key_d;
    logic          simo_q, simo_d;
    logic          mode_q, mode_d;
    logic [127:0]  result_q, result_d;
`ifdef AES_SPI_MASTER_SS_EN
    logic          ss_n_q, ss_n_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            msg_q    <= '0;
            key_q    <= '0;
            simo_q   <= 1'b0;
            mode_q   <= 1'b0;
            result_q <= '0;
`ifdef AES_SPI_MASTER_SS_EN
            ss_n_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            msg_q    <= msg_d;
            key_q    <= key_d;
            simo_q   <= simo_d;
            mode_q   <= mode_d;
            result_q <= result_d;
`ifdef AES_SPI_MASTER_SS_EN
            ss_n_q   <= ss_n_d;
`endif
        end
    end

    // SIMO is registered one bit ahead: each edge loads the bit for the coming cycle,
    // so the shift registers always hold the next bit to send in bit 0.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        msg_d    = msg_q;
        key_d    = key_q;
        simo_d   = simo_q;
        mode_d   = mode_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    simo_d  = msg_in[0];
                    msg_d   = msg_in >> 1;
                    key_d   = key_in;
                    mode_d  = mode_in;
                    cnt_d   = '0;
                    state_d = MSG;
                end
            end
            MSG: begin
                if (cnt_q == 8'd127) begin
                    simo_d  = key_q[0];
                    key_d   = key_q >> 1;
                    cnt_d   = '0;
                    state_d = KEY;
                end else begin
                    simo_d = msg_q[0];
                    msg_d  = msg_q >> 1;
                    cnt_d  = cnt_q + 8'd1;
                end
            end
            KEY: begin
                if (cnt_q == KEY_LAST) begin
                    simo_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = (TURN == 0) ? RX : GAP;
                end else begin
                    simo_d = key_q[0];
                    key_d  = key_q >> 1;
                    cnt_d  = cnt_q + 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = RX;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RX: begin
                result_d = {SOMI, result_q[127:1]};
                if (cnt_q == 8'd127) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef AES_SPI_MASTER_SS_EN
        ss_n_d = !(state_d inside {MSG, KEY, GAP, RX});
`endif
    end

    assign SIMO   = simo_q;
    assign mode   = mode_q;
    assign result = result_q;
    assign busy   = state_q inside {MSG, KEY, GAP, RX};
    assign done   = (state_q == DONE);
`ifdef AES_SPI_MASTER_SS_EN
    assign ss_n   = ss_n_q;
`endif

endmodule

// File: tb/tb_aes_spi_master.sv
// Scoreboard bench for aes_spi_master: an AES-128 link (Nk=4, TURN=2) and an AES-256 link
// (Nk=8, TURN=0) driven by directed FIPS-197 vectors against a bench slave model.
`timescale 1ns/1ps
module tb_aes_spi_master;
    typedef struct {
        logic [127:0] res;
        logic         md;
        int           e0;
        int           lat;
        logic [127:0] msg;
        logic [255:0] key;
    } exp_t;

    localparam int RX4 = 128 + 128 + 2 + 1;
    localparam int RX8 = 128 + 256 + 0 + 1;

    logic [127:0] pt     = 128'h00112233445566778899aabbccddeeff;
    logic [127:0] key128 = 128'h000102030405060708090a0b0c0d0e0f;
    logic [255:0] key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    logic [127:0] resp4  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    logic [127:0] resp8  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start4, mode_in4, simo4, mode4, somi4 = 1'b0, busy4, done4;
    logic start8, mode_in8, simo8, mode8, somi8 = 1'b0, busy8, done8;
    logic [127:0] msg4, msg8, res4, res8;
    logic [127:0] key4;
    logic [255:0] key8;
`ifdef AES_SPI_MASTER_SS_EN
    logic ss4, ss8;
`endif

    int n_vec = 0, n_bad = 0, cyc = 0, done4_cnt = 0, done8_cnt = 0;
    exp_t q4[$], q8[$];
    exp_t e4, e8;

    aes_spi_master #(.Nk(4), .TURN(2)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode_in(mode_in4), .msg_in(msg4),
        .key_in(key4), .SIMO(simo4), .mode(mode4), .SOMI(somi4), .result(res4),
        .busy(busy4), .done(done4)
`ifdef AES_SPI_MASTER_SS_EN
        , .ss_n(ss4)
`endif
    );

    aes_spi_master #(.Nk(8), .TURN(0)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode_in(mode_in8), .msg_in(msg8),
        .key_in(key8), .SIMO(simo8), .mode(mode8), .SOMI(somi8), .result(res8),
        .busy(busy8), .done(done8)
`ifdef AES_SPI_MASTER_SS_EN
        , .ss_n(ss8)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Slave models: count cycles from busy rising, record SIMO, return the cipher on SOMI.
    int c4 = 0, c8 = 0;
    logic pb4 = 1'b0, pb8 = 1'b0;
    logic [127:0] cm4 = '0, cm8 = '0;
    logic [255:0] ck4 = '0, ck8 = '0;

    always @(negedge clk) begin
        if (busy4) begin
            c4 = pb4 ? c4 + 1 : 1;
            if (c4 == 1) begin cm4 = '0; ck4 = '0; end
            if (c4 <= 128) cm4[c4-1] = simo4;
            else if (c4 <= 256) ck4[c4-129] = simo4;
            somi4 = (c4 >= RX4 && c4 < RX4 + 128) ? resp4[c4-RX4] : 1'b0;
        end else somi4 = 1'b0;
        pb4 = busy4;
    end

    always @(negedge clk) begin
        if (busy8) begin
            c8 = pb8 ? c8 + 1 : 1;
            if (c8 == 1) begin cm8 = '0; ck8 = '0; end
            if (c8 <= 128) cm8[c8-1] = simo8;
            else if (c8 <= 384) ck8[c8-129] = simo8;
            somi8 = (c8 >= RX8 && c8 < RX8 + 128) ? resp8[c8-RX8] : 1'b0;
        end else somi8 = 1'b0;
        pb8 = busy8;
    end

    always @(negedge rst_n) begin
        q4.delete();
        q8.delete();
    end

    // Monitors: pop the oldest expected transfer on every done pulse.
    always @(negedge clk) if (done4) begin
        done4_cnt++;
        if (q4.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL dut4_spurious_done: got done=1 required no pending transfer");
        end else begin
            e4 = q4.pop_front();
            check("dut4_latency", 256'(cyc - e4.e0), 256'(e4.lat));
            check("dut4_result", res4, e4.res);
            check("dut4_mode", mode4, e4.md);
            check("dut4_busy_in_done", busy4, 0);
            check("dut4_msg_stream", cm4, e4.msg);
            check("dut4_key_stream", ck4, e4.key);
        end
    end

    always @(negedge clk) if (done8) begin
        done8_cnt++;
        if (q8.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL dut8_spurious_done: got done=1 required no pending transfer");
        end else begin
            e8 = q8.pop_front();
            check("dut8_latency", 256'(cyc - e8.e0), 256'(e8.lat));
            check("dut8_result", res8, e8.res);
            check("dut8_mode", mode8, e8.md);
            check("dut8_busy_in_done", busy8, 0);
            check("dut8_msg_stream", cm8, e8.msg);
            check("dut8_key_stream", ck8, e8.key);
        end
    end

`ifdef AES_SPI_MASTER_SS_EN
    always @(negedge clk) if (rst_n) begin
        check("dut4_ss_n", ss4, !busy4);
        check("dut8_ss_n", ss8, !busy8);
    end
`endif

    task automatic issue4(input logic [127:0] m, input logic [127:0] k, input logic md);
        exp_t e;
        msg4 = m; key4 = k; mode_in4 = md; start4 = 1'b1;
        e.res = resp4; e.md = md; e.e0 = cyc; e.lat = 387; e.msg = m; e.key = {128'h0, k};
        q4.push_back(e);
    endtask

    task automatic issue8(input logic [127:0] m, input logic [255:0] k, input logic md);
        exp_t e;
        msg8 = m; key8 = k; mode_in8 = md; start8 = 1'b1;
        e.res = resp8; e.md = md; e.e0 = cyc; e.lat = 513; e.msg = m; e.key = k;
        q8.push_back(e);
    endtask

    task automatic scramble();
        msg4 = {$urandom, $urandom, $urandom, $urandom};
        key4 = {$urandom, $urandom, $urandom, $urandom};
        msg8 = {$urandom, $urandom, $urandom, $urandom};
        key8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        mode_in4 = 1'($urandom);
        mode_in8 = 1'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((q4.size() != 0 || q8.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q4.size() != 0 || q8.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL wait_done: got %0d transfers pending after %0d cycles required 0",
                     q4.size() + q8.size(), budget);
            q4.delete();
            q8.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int saved;
        start4 = 1'b1; start8 = 1'b1;
        scramble();
        repeat (3) @(negedge clk);
        check("rst_simo4", simo4, 0);   check("rst_mode4", mode4, 0);
        check("rst_busy4", busy4, 0);   check("rst_done4", done4, 0);
        check("rst_result4", res4, 0);
        check("rst_simo8", simo8, 0);   check("rst_mode8", mode8, 0);
        check("rst_busy8", busy8, 0);   check("rst_done8", done8, 0);
        check("rst_result8", res8, 0);
`ifdef AES_SPI_MASTER_SS_EN
        check("rst_ss4", ss4, 1);
        check("rst_ss8", ss8, 1);
`endif
        start4 = 1'b0; start8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // FIPS-197 AES-128 on u4 and AES-256 on u8 in parallel; inputs change while busy.
        issue4(pt, key128, 1'b0);
        issue8(pt, key256, 1'b1);
        @(negedge clk);
        start4 = 1'b0; start8 = 1'b0;
        scramble();
        wait_done(700);

        // A start with all-ones data at cycle 50 must be ignored.
        saved = done4_cnt;
        issue4(pt, key128, 1'b0);
        repeat (50) @(negedge clk);
        start4 = 1'b0;
        msg4 = '1; key4 = '1; mode_in4 = 1'b1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done(500);
        repeat (5) @(negedge clk);
        check("ignore_busy_done_count", 256'(done4_cnt), 256'(saved + 1));

        // Abort during KEY cycle 10: outputs clear at once and no done follows.
        issue4(pt, key128, 1'b1);
        @(negedge clk);
        start4 = 1'b0;
        repeat (138) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_simo4", simo4, 0);  check("abort_mode4", mode4, 0);
        check("abort_busy4", busy4, 0);  check("abort_done4", done4, 0);
        check("abort_result4", res4, 0);
        saved = done4_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (450) @(negedge clk);
        check("abort_no_done", 256'(done4_cnt), 256'(saved));

        issue4(pt, key128, 1'b1);
        @(negedge clk);
        start4 = 1'b0;
        mode_in4 = 1'b0;
        wait_done(500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/aes_spi_master.md
# aes_spi_master

Upstream serializer for the AES SPI link. Accepts a 128-bit plaintext block and an Nk-word cipher key in parallel, shifts them LSB-first onto SIMO one bit per clock, waits a programmable turnaround, then captures the 128-bit cipher result from SOMI and presents it in parallel with a one-cycle done pulse. Drives the encryption slave's SIMO and mode inputs and consumes its SOMI output, all on the shared system clock.

## Interface
- Nk, 4, key length in 32-bit words; legal values 4, 6, 8.
- TURN, 2, idle cycles between the last key bit and the first SOMI sample; legal range 0..15.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- mode_in  in  1  operation select, 0 = encrypt, 1 = decrypt; latched with start.
- msg_in  in  128  plaintext block; latched with start.
- key_in  in  Nk*32  cipher key; latched with start.
- SIMO  out  1  serial data to slave.
- mode  out  1  latched mode to slave.
- SOMI  in  1  serial data from slave.
- result  out  128  captured slave output.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse, result valid.

## Operation
- States: IDLE, MSG, KEY, GAP, RX, DONE. 8-bit bit counter `cnt`.
- IDLE: start=1 loads the msg and key shift registers, latches mode_in into mode, and sets cnt=0 → MSG. start=0 → stay.
- MSG: SIMO = msg bit cnt (bit 0 first); msg register shifts right each cycle; after bit 127, cnt=0 → KEY.
- KEY: SIMO = key bit cnt (bit 0 first); after bit Nk*32-1, cnt=0 → GAP, or → RX directly when TURN=0.
- GAP: SIMO=0 for exactly TURN cycles → RX.
- RX: each edge, result <= {SOMI, result[127:1]}; after 128 samples → DONE. result is updated in place; the first captured bit ends in result[0].
- DONE: done=1 for one cycle, result stable → IDLE.
- start outside IDLE is ignored, including start in DONE. Input changes while busy have no effect.
- mode holds its latched value until the next accepted start.

## Timing
- Reset values: SIMO=0, mode=0, result=0, busy=0, done=0, state IDLE, cnt=0, shift registers 0.
- Edge E0 samples start. SIMO carries msg[0] during the cycle after E0, through msg[127] at cycle 128. key[0] follows at cycle 129. SIMO is registered, so it never glitches.
- busy=1 from the cycle after E0 through the last RX cycle; busy=0 in DONE.
- Latency from E0 to the done cycle: 128 + Nk*32 + TURN + 128 + 1 cycles. For Nk=4 and TURN=2 this is 387.
- Back-to-back: the earliest next accept is one cycle after DONE, in IDLE.
- rst_n low at any point aborts the transfer immediately and returns all outputs to their reset values. No done pulse is produced for the aborted transfer.
- cnt cannot exceed 255; Nk=8 (256 key bits) uses terminal count 255.

## Configuration
- AES_SPI_MASTER_SS_EN: when defined, adds output port ss_n (1 bit, reset 1). ss_n=0 from the first MSG cycle through the last RX cycle and returns to 1 in DONE. The slave select toggles only on clk edges.
- Undefined: no ss_n port. The slave relies only on bit counting; all other behaviour is identical.

## Test plan
- Reset: drive rst_n=0 with random inputs → SIMO=0, mode=0, busy=0, done=0, result=0.
- FIPS-197 AES-128 (Nk=4, TURN=2):
  - Stimulus: msg_in=00112233445566778899aabbccddeeff, key_in=000102030405060708090a0b0c0d0e0f. A bench slave model returns 69c4e0d86a7b0430d8cdb78070b4c55a LSB-first starting in the first RX cycle.
  - Required response: SIMO stream matches msg then key bit-for-bit; done occurs 387 cycles after E0; result=69c4e0d86a7b0430d8cdb78070b4c55a.
- Ignore while busy: pulse start with msg_in=ffff…ff at cycle 50 of a transfer → the serialized stream and result are unchanged, and there is exactly one done.
- Nk=8, TURN=0: 256 key bits are sent and RX starts the cycle after key bit 255. Latency is 128+256+0+128+1 = 513 cycles.
- Reset mid-transfer: assert rst_n=0 during KEY cycle 10 → all outputs return to reset values within the same cycle, no done pulse follows, and a new start after release completes normally.
- SS (macro defined): ss_n falls on the first MSG cycle and rises on the DONE cycle. Low duration is 128 + Nk*32 + TURN + 128 cycles.
